pooling_feeder: RTL and testbench
=================================

Name: pooling_feeder

Overview:
Transmit side of the pooling-array input interface. Accepts the feature-interleaved result stream from the convolution layer and buffers one horizontal pooling window (KERNEL_SIZE columns x TOTAL_FEATURE features). It then replays each feature's window to the pooling array as a fixed-format transaction with stable feature index and row tags. It sits between the conv output stage and the pooling array. It owns row/column/feature sequencing for one frame.

Parameters:
DATA_WIDTH, 32, word width (IEEE-754 single).
TOTAL_FEATURE, 4, features per pixel position.
KERNEL_SIZE, 2, pooling window width/height.
FEATURE_ROWS, 6, rows per feature map.
FEATURE_COLS, 6, columns per feature map; must be a multiple of KERNEL_SIZE.
FEATURE_WIDTH, 2, width of the feature index.
ROW_WIDTH, 3, width of the row tag.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream word valid
in_data  in  DATA_WIDTH  upstream word; order is row, column, then feature 0..TOTAL_FEATURE-1
in_ready  out  1  feeder accepts in_data this cycle
pool_out_valid  in  1  pooling array result strobe (used only with the optional feature)
pool_input_valid  out  1  transaction start strobe to the pooling array
pool_data  out  DATA_WIDTH  window sample to the pooling array
pool_feature_idx  out  FEATURE_WIDTH  feature tag, stable for a whole transaction
pool_feature_row  out  ROW_WIDTH  row tag, stable for a whole transaction
row_done  out  1  one-cycle pulse after the last transaction of a row
frame_done  out  1  one-cycle pulse after the last transaction of the frame

Behaviour:
- Reset values: all outputs 0; all counters 0; state FILL; buffer cleared.
- Reset is asynchronous. Asserting it mid-transaction aborts the transaction immediately and discards any partial buffer.
- FILL state:
  - in_ready=1.
  - Each in_valid&&in_ready handshake writes buf[word_cnt / TOTAL_FEATURE][word_cnt % TOTAL_FEATURE].
  - Bubbles (in_valid=0) are allowed and hold word_cnt.
  - After word KERNEL_SIZE*TOTAL_FEATURE-1 is accepted, the next state is ISSUE with feat=0 and phase=0.
- ISSUE state:
  - in_ready=0; input offered while in_ready=0 is not consumed.
  - Phase counter is 0..KERNEL_SIZE+2.
  - Phase 0: pool_input_valid=1, pool_data=0.
  - Phases 1..KERNEL_SIZE: pool_data=buf[phase-1][feat].
  - Phase KERNEL_SIZE+1: pool_data=0, slot for the downstream previous-result compare.
  - Phase KERNEL_SIZE+2: output wait slot. Feat increments; after the last feature the block leaves ISSUE.
  - pool_data=0 in every other cycle.
  - pool_feature_idx=feat and pool_feature_row=row are held constant from phase 0 through phase KERNEL_SIZE+2 inclusive.
- Transaction timing:
  - Each transaction lasts KERNEL_SIZE+3 cycles (5 with defaults).
  - Transactions for feat and feat+1 are back-to-back, so pool_input_valid pulses are 5 cycles apart.
- End of the last feature:
  - col advances by KERNEL_SIZE and the state returns to FILL.
  - If col wraps (col+KERNEL_SIZE==FEATURE_COLS): col=0, row_done pulses, row increments.
  - If row also wraps (row==FEATURE_ROWS-1): row=0 and frame_done pulses in the same cycle as row_done.
- Throughput: FILL takes at least KERNEL_SIZE*TOTAL_FEATURE cycles, ISSUE takes TOTAL_FEATURE*(KERNEL_SIZE+3) cycles, with no overlap between them.
- The vertical pooling pair is completed downstream (prev_result clear on odd rows). The feeder only guarantees that row tags are correct and monotonic.

Optional Feature:
POOLING_FEEDER_ACK_EN.
- Defined:
  - Phase KERNEL_SIZE+2 holds until pool_out_valid=1, then advances.
  - A pool_out_valid arriving in any other phase sets a sticky protocol_error output, which is added only under this macro and cleared only by reset.
  - pool_out_valid arriving in FILL state also sets protocol_error.
- Undefined: fixed-period timing; pool_out_valid is ignored.

Decomposition:
- Shared package pooling_pkg holds:
  - DATA_WIDTH, TOTAL_FEATURE, KERNEL_SIZE, FEATURE_ROWS, FEATURE_COLS, FEATURE_WIDTH, ROW_WIDTH.
  - typedef feeder_state_t {FILL, ISSUE}.
  - localparam TXN_CYCLES = KERNEL_SIZE+3.
- One sub-module is natural: pooling_window_buffer, the KERNEL_SIZE x TOTAL_FEATURE register file with a write port indexed by word_cnt, a read port indexed by (phase-1, feat), and a synchronous clear.

Test Plan:
- Single window: push 8 words 1.0..8.0 after reset. Expect 4 transactions, 5 cycles each.
  - Feature 0 carries pool_data 1.0 then 5.0.
  - Feature 3 carries 4.0 then 8.0.
  - pool_input_valid at t0, t0+5, t0+10, t0+15.
- Backpressure: drive in_valid during ISSUE. Expect in_ready=0 and no word consumed; the words are accepted only after the return to FILL.
- Row/frame wrap: stream a full 6x6x4 frame.
  - Expect row_done after every 3rd window.
  - Expect pool_feature_row sequence 0..5.
  - Expect frame_done coincident with the final row_done, then row=0 and col=0.
- Reset mid-transaction: assert rst_n=0 at phase 2 of feature 1. Expect all outputs 0 and the state FILL with word_cnt=0. A fresh window then replays from feature 0.
- Bubbles: in_valid toggles 1/0 while pushing 8 words. Expect the same output as the single-window case, with the first transaction delayed.
- With POOLING_FEEDER_ACK_EN: withhold pool_out_valid for 10 cycles. Expect phase 4 to hold and the tags to stay stable. A spurious pool_out_valid at phase 1 sets protocol_error=1.

Source files
------------

// File: rtl/pooling_pkg.sv
// Shared sizing and state encoding for the pooling-array input feeder.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package pooling_pkg;
    localparam int DATA_WIDTH    = 32;
    localparam int TOTAL_FEATURE = 4;
    localparam int KERNEL_SIZE   = 2;
    localparam int FEATURE_ROWS  = 6;
    localparam int FEATURE_COLS  = 6;
    localparam int FEATURE_WIDTH = 2;
    localparam int ROW_WIDTH     = 3;

    // One transaction: start, KERNEL_SIZE samples, compare slot, output wait slot.
    localparam int TXN_CYCLES = KERNEL_SIZE + 3;
    localparam int WIN_WORDS  = KERNEL_SIZE * TOTAL_FEATURE;
    localparam int WCNT_W     = $clog2(WIN_WORDS);
    localparam int PHASE_W    = $clog2(TXN_CYCLES);
    localparam int COL_W      = $clog2(FEATURE_COLS);

    typedef enum logic {
        FILL  = 1'b0,
        ISSUE = 1'b1
    } feeder_state_t;
endpackage

// File: rtl/pooling_window_buffer.sv
// KERNEL_SIZE x TOTAL_FEATURE window store, written in arrival order, read by (column, feature).
// Latency: write lands at the next edge; read is combinational.
// Backpressure: none; the owner sequences writes and reads.
// Ports: wr_en/wr_idx/wr_dat write port (wr_idx = column*TOTAL_FEATURE + feature),
//        rd_col/rd_feat -> rd_dat read port, clr synchronously zeroes every entry.
module pooling_window_buffer
    import pooling_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [WCNT_W-1:0]        wr_idx,
    input  logic [DATA_WIDTH-1:0]    wr_dat,
    input  logic [PHASE_W-1:0]       rd_col,
    input  logic [FEATURE_WIDTH-1:0] rd_feat,
    output logic [DATA_WIDTH-1:0]    rd_dat
);
    logic [DATA_WIDTH-1:0] mem_q [WIN_WORDS];
    logic [DATA_WIDTH-1:0] mem_d [WIN_WORDS];
    logic [WCNT_W-1:0]     rd_idx;

    always_comb begin
        mem_d = mem_q;
        if (clr) begin
            for (int i = 0; i < WIN_WORDS; i++) begin
                mem_d[i] = '0;
            end
        end else if (wr_en) begin
            mem_d[wr_idx] = wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIN_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Out-of-window read addresses occur in non-sample phases; the owner masks them.
    assign rd_idx = WCNT_W'(rd_col) * WCNT_W'(TOTAL_FEATURE) + WCNT_W'(rd_feat);
    assign rd_dat = mem_q[rd_idx];
endmodule

// File: rtl/pooling_feeder.sv
// Buffers one horizontal pooling window from the conv stream, then replays it per feature to the pooling array.
// Latency: first transaction starts the cycle after the last window word; each transaction is TXN_CYCLES long.
// Backpressure: in_ready is low for the whole replay; with POOLING_FEEDER_ACK_EN the last phase waits for pool_out_valid.
// Ports: in_valid/in_data/in_ready upstream handshake; pool_input_valid/pool_data/pool_feature_idx/pool_feature_row
//        to the array; pool_out_valid array result strobe; row_done/frame_done sequencing pulses;
//        protocol_error (POOLING_FEEDER_ACK_EN only) sticky misuse flag of pool_out_valid.
module pooling_feeder
    import pooling_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic                     in_ready,
    input  logic                     pool_out_valid,
    output logic                     pool_input_valid,
    output logic [DATA_WIDTH-1:0]    pool_data,
    output logic [FEATURE_WIDTH-1:0] pool_feature_idx,
    output logic [ROW_WIDTH-1:0]     pool_feature_row,
`ifdef POOLING_FEEDER_ACK_EN
    output logic                     protocol_error,
`endif
    output logic                     row_done,
    output logic                     frame_done
);
    localparam logic [WCNT_W-1:0]        WCNT_LAST  = WCNT_W'(WIN_WORDS - 1);
    localparam logic [PHASE_W-1:0]       PHASE_LAST = PHASE_W'(TXN_CYCLES - 1);
    localparam logic [PHASE_W-1:0]       PHASE_KS   = PHASE_W'(KERNEL_SIZE);
    localparam logic [FEATURE_WIDTH-1:0] FEAT_LAST  = FEATURE_WIDTH'(TOTAL_FEATURE - 1);
    localparam logic [ROW_WIDTH-1:0]     ROW_LAST   = ROW_WIDTH'(FEATURE_ROWS - 1);
    localparam logic [COL_W-1:0]         COL_LAST   = COL_W'(FEATURE_COLS - KERNEL_SIZE);

    feeder_state_t              state_q, state_d;
    logic [WCNT_W-1:0]          word_cnt_q, word_cnt_d;
    logic [PHASE_W-1:0]         phase_q, phase_d;
    logic [FEATURE_WIDTH-1:0]   feat_q, feat_d;
    logic [ROW_WIDTH-1:0]       row_q, row_d;
    logic [COL_W-1:0]           col_q, col_d;
    logic                       in_ready_q, in_ready_d;
    logic                       row_done_q, row_done_d;
    logic                       frame_done_q, frame_done_d;

    logic                       buf_wr, buf_clr;
    logic [DATA_WIDTH-1:0]      buf_rd_dat;
    logic                       is_issue, last_phase, ack_ok;

    assign is_issue   = (state_q == ISSUE);
    assign last_phase = (phase_q == PHASE_LAST);

`ifdef POOLING_FEEDER_ACK_EN
    logic protocol_error_q, protocol_error_d;
    assign ack_ok = pool_out_valid;
    // A result strobe is legal only in the output wait slot of a transaction.
    assign protocol_error_d = protocol_error_q | (pool_out_valid & ~(is_issue & last_phase));
    assign protocol_error   = protocol_error_q;
`else
    logic unused_pool_out_valid;
    assign unused_pool_out_valid = pool_out_valid;
    assign ack_ok = 1'b1;
`endif

    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        phase_d      = phase_q;
        feat_d       = feat_q;
        row_d        = row_q;
        col_d        = col_q;
        row_done_d   = 1'b0;
        frame_done_d = 1'b0;
        buf_wr       = 1'b0;
        buf_clr      = 1'b0;
        case (state_q)
            FILL: begin
                if (in_valid && in_ready_q) begin
                    buf_wr = 1'b1;
                    if (word_cnt_q == WCNT_LAST) begin
                        word_cnt_d = '0;
                        state_d    = ISSUE;
                        phase_d    = '0;
                        feat_d     = '0;
                    end else begin
                        word_cnt_d = word_cnt_q + WCNT_W'(1);
                    end
                end
            end
            ISSUE: begin
                if (!last_phase) begin
                    phase_d = phase_q + PHASE_W'(1);
                end else if (ack_ok) begin
                    phase_d = '0;
                    if (feat_q == FEAT_LAST) begin
                        // Window fully replayed: step to the next window position.
                        feat_d  = '0;
                        state_d = FILL;
                        buf_clr = 1'b1;
                        if (col_q == COL_LAST) begin
                            col_d      = '0;
                            row_done_d = 1'b1;
                            if (row_q == ROW_LAST) begin
                                row_d        = '0;
                                frame_done_d = 1'b1;
                            end else begin
                                row_d = row_q + ROW_WIDTH'(1);
                            end
                        end else begin
                            col_d = col_q + COL_W'(KERNEL_SIZE);
                        end
                    end else begin
                        feat_d = feat_q + FEATURE_WIDTH'(1);
                    end
                end
            end
            default: state_d = FILL;
        endcase
        in_ready_d = (state_d == FILL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FILL;
            word_cnt_q   <= '0;
            phase_q      <= '0;
            feat_q       <= '0;
            row_q        <= '0;
            col_q        <= '0;
            in_ready_q   <= 1'b0;
            row_done_q   <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef POOLING_FEEDER_ACK_EN
            protocol_error_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            phase_q      <= phase_d;
            feat_q       <= feat_d;
            row_q        <= row_d;
            col_q        <= col_d;
            in_ready_q   <= in_ready_d;
            row_done_q   <= row_done_d;
            frame_done_q <= frame_done_d;
`ifdef POOLING_FEEDER_ACK_EN
            protocol_error_q <= protocol_error_d;
`endif
        end
    end

    pooling_window_buffer u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (buf_clr),
        .wr_en   (buf_wr),
        .wr_idx  (word_cnt_q),
        .wr_dat  (in_data),
        .rd_col  (phase_q - PHASE_W'(1)),
        .rd_feat (feat_q),
        .rd_dat  (buf_rd_dat)
    );

    assign in_ready         = in_ready_q;
    assign pool_input_valid = is_issue && (phase_q == '0);
    assign pool_data        = (is_issue && (phase_q != '0) && (phase_q <= PHASE_KS)) ? buf_rd_dat : '0;
    assign pool_feature_idx = is_issue ? feat_q : '0;
    assign pool_feature_row = is_issue ? row_q : '0;
    assign row_done         = row_done_q;
    assign frame_done       = frame_done_q;
endmodule

// File: tb/tb_pooling_feeder.sv
// Directed bench for pooling_feeder: window replay table, bubbles, backpressure, row/frame wrap,
// mid-transaction reset, and (with POOLING_FEEDER_ACK_EN) the acknowledge hold and protocol_error.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_pooling_feeder;
    import pooling_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     in_valid;
    logic [DATA_WIDTH-1:0]    in_data;
    logic                     in_ready;
    logic                     pool_out_valid;
    logic                     pool_input_valid;
    logic [DATA_WIDTH-1:0]    pool_data;
    logic [FEATURE_WIDTH-1:0] pool_feature_idx;
    logic [ROW_WIDTH-1:0]     pool_feature_row;
    logic                     row_done;
    logic                     frame_done;
`ifdef POOLING_FEEDER_ACK_EN
    logic                     protocol_error;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pooling_feeder dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_ready         (in_ready),
        .pool_out_valid   (pool_out_valid),
        .pool_input_valid (pool_input_valid),
        .pool_data        (pool_data),
        .pool_feature_idx (pool_feature_idx),
        .pool_feature_row (pool_feature_row),
`ifdef POOLING_FEEDER_ACK_EN
        .protocol_error   (protocol_error),
`endif
        .row_done         (row_done),
        .frame_done       (frame_done)
    );

    // One record per feature: the two words that feature receives (inputs, column 0 and 1)
    // and the hand-computed samples expected in phases 1 and 2.
    typedef struct {
        logic [1:0]  feat;
        logic [31:0] w_lo;
        logic [31:0] w_hi;
        logic [31:0] exp_d1;
        logic [31:0] exp_d2;
    } vec_t;
    vec_t tbl [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] tbl_word(input int i);
        return (i < 4) ? tbl[i].w_lo : tbl[i-4].w_hi;
    endfunction

    // Entered and left 1 unit after a rising edge; spans exactly one cycle.
    task automatic check_cycle(input logic ev, input logic [31:0] ed, input logic [1:0] ei,
                               input logic [2:0] er, input logic ack);
        pool_out_valid = ack;
        @(negedge clk);
        chk("pool_input_valid", 32'(pool_input_valid), 32'(ev));
        chk("pool_data", pool_data, ed);
        chk("pool_feature_idx", 32'(pool_feature_idx), 32'(ei));
        chk("pool_feature_row", 32'(pool_feature_row), 32'(er));
        chk("in_ready_issue", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        pool_out_valid = 1'b0;
    endtask

    task automatic check_txn(input logic [1:0] f, input logic [31:0] d1, input logic [31:0] d2,
                             input logic [2:0] row);
        for (int p = 0; p < 5; p++) begin
            check_cycle(p == 0, (p == 1) ? d1 : (p == 2) ? d2 : 32'd0, f, row, p == 4);
        end
    endtask

    task automatic check_fill(input logic rd, input logic fd);
        @(negedge clk);
        chk("in_ready_fill", 32'(in_ready), 32'd1);
        chk("row_done", 32'(row_done), 32'(rd));
        chk("frame_done", 32'(frame_done), 32'(fd));
        chk("pool_input_valid_fill", 32'(pool_input_valid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w, input bit bubble);
        bit hs;
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = w;
        do begin
            hs = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!hs && n < 200);
        chk("push_accept", 32'(hs), 32'd1);
        in_valid = 1'b0;
        if (bubble) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_tbl(input bit bubbles);
        for (int i = 0; i < 8; i++) push_word(tbl_word(i), bubbles && (i < 7));
    endtask

    task automatic check_tbl(input logic [2:0] row);
        for (int k = 0; k < 4; k++) check_txn(tbl[k].feat, tbl[k].exp_d1, tbl[k].exp_d2, row);
    endtask

    task automatic push_gen(input logic [31:0] base);
        for (int i = 0; i < 8; i++) push_word(base + 32'(i), 1'b0);
    endtask

    task automatic check_gen(input logic [31:0] base, input logic [2:0] row, input logic rd, input logic fd);
        for (int f = 0; f < 4; f++) check_txn(2'(f), base + 32'(f), base + 32'(f + 4), row);
        check_fill(rd, fd);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{2'd0, 32'h3F80_0000, 32'h40A0_0000, 32'h3F80_0000, 32'h40A0_0000}; // 1.0 / 5.0
        tbl[1] = '{2'd1, 32'h4000_0000, 32'h40C0_0000, 32'h4000_0000, 32'h40C0_0000}; // 2.0 / 6.0
        tbl[2] = '{2'd2, 32'h4040_0000, 32'h40E0_0000, 32'h4040_0000, 32'h40E0_0000}; // 3.0 / 7.0
        tbl[3] = '{2'd3, 32'h4080_0000, 32'h4100_0000, 32'h4080_0000, 32'h4100_0000}; // 4.0 / 8.0

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; pool_out_valid = 1'b0;
        #3;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_pool_input_valid", 32'(pool_input_valid), 32'd0);
        chk("rst_pool_data", pool_data, 32'd0);
        chk("rst_feature_idx", 32'(pool_feature_idx), 32'd0);
        chk("rst_feature_row", 32'(pool_feature_row), 32'd0);
        chk("rst_row_done", 32'(row_done), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        #9;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Window A (row 0, col 0): back-to-back words, table replay, valid every 5 cycles.
        push_tbl(1'b0);
        check_tbl(3'd0);
        check_fill(1'b0, 1'b0);

        // Window B (col 2): bubbles on input, and a word offered throughout the replay.
        push_tbl(1'b1);
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        check_tbl(3'd0);
        in_valid = 1'b0;
        check_fill(1'b0, 1'b0);

        // Window C (col 4): row wraps; the stray word must not have shifted this window.
        push_gen(32'h0000_0100);
        check_gen(32'h0000_0100, 3'd0, 1'b1, 1'b0);

        // Window D on row 1, reset during phase 2 of feature 1.
        push_gen(32'h0000_0200);
        check_txn(2'd0, 32'h0000_0200, 32'h0000_0204, 3'd1);
        check_cycle(1'b1, 32'd0, 2'd1, 3'd1, 1'b0);
        check_cycle(1'b0, 32'h0000_0201, 2'd1, 3'd1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_pool_input_valid", 32'(pool_input_valid), 32'd0);
        chk("midrst_pool_data", pool_data, 32'd0);
        chk("midrst_feature_idx", 32'(pool_feature_idx), 32'd0);
        chk("midrst_feature_row", 32'(pool_feature_row), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Fresh window replays from feature 0 on row 0.
        push_tbl(1'b0);
        check_tbl(3'd0);
        check_fill(1'b0, 1'b0);

        // Full 6x6x4 frame from a clean start, then one window of the next frame.
        do_reset();
        for (int w = 0; w < 19; w++) begin
            push_gen(32'h0000_1000 + 32'(w * 16));
            check_gen(32'h0000_1000 + 32'(w * 16), 3'((w % 18) / 3), (w % 3) == 2, w == 17);
        end

`ifdef POOLING_FEEDER_ACK_EN
        do_reset();
        chk("perr_after_reset", 32'(protocol_error), 32'd0);
        push_gen(32'h0000_3000);
        check_cycle(1'b1, 32'd0, 2'd0, 3'd0, 1'b0);
        check_cycle(1'b0, 32'h0000_3000, 2'd0, 3'd0, 1'b1);   // spurious strobe in phase 1
        check_cycle(1'b0, 32'h0000_3004, 2'd0, 3'd0, 1'b0);
        chk("perr_sticky", 32'(protocol_error), 32'd1);
        check_cycle(1'b0, 32'd0, 2'd0, 3'd0, 1'b0);
        for (int i = 0; i < 10; i++) check_cycle(1'b0, 32'd0, 2'd0, 3'd0, 1'b0);
        check_cycle(1'b0, 32'd0, 2'd0, 3'd0, 1'b1);
        check_cycle(1'b1, 32'd0, 2'd1, 3'd0, 1'b0);
        chk("perr_held", 32'(protocol_error), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
